// File: rtl/axis_packer_pkg.sv
// Shared helpers for the AXI-Stream width packer: count-port width and the
// elaboration-time sanity check on the packing ratio.
package axis_packer_pkg;

    function automatic int cnt_w(input int ratio);
        return $clog2(ratio + 1);
    endfunction

    function automatic bit ratio_ok(input int ratio);
        return ratio >= 2;
    endfunction

endpackage

// File: rtl/axis_packer.sv
// Packs RATIO narrow AXI-Stream beats into one wide beat, little-endian lanes.
// Optional partial-word flush (flush_i, m_count_o) enabled by AXIS_PACKER_FLUSH_EN.
module axis_packer
    import axis_packer_pkg::*;
#(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [IN_WIDTH-1:0]           s_data_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    output logic [IN_WIDTH*RATIO-1:0]     m_data_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i
`ifdef AXIS_PACKER_FLUSH_EN
    ,
    input  logic                          flush_i,
    output logic [cnt_w(RATIO)-1:0]       m_count_o
`endif
);

    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int ACC_WIDTH = IN_WIDTH * (RATIO - 1);
    localparam int CW        = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    if (!ratio_ok(RATIO)) begin : g_ratio_check
        $fatal(1, "axis_packer: RATIO must be >= 2");
    end

    logic [CW-1:0]        cnt, cnt_n;
    logic [ACC_WIDTH-1:0] acc, acc_n;
    logic [OUT_WIDTH-1:0] data_n;
    logic                 valid_n;
    logic                 flush_pend;
    logic                 slot_free;
    logic                 in_xfer;

`ifdef AXIS_PACKER_FLUSH_EN
    localparam int MW = cnt_w(RATIO);
    logic [MW-1:0] count_n;
    logic          pend_n;
`else
    assign flush_pend = 1'b0;
`endif

    always_comb begin
        cnt_n   = cnt;
        acc_n   = acc;
        data_n  = m_data_o;
        valid_n = m_valid_o;
`ifdef AXIS_PACKER_FLUSH_EN
        count_n = m_count_o;
        pend_n  = flush_pend;
`endif
        slot_free = !m_valid_o | m_ready_i;
        s_ready_o = !((cnt == LAST) & !slot_free) & !flush_pend;
        in_xfer   = s_valid_i & s_ready_o;

        if (m_valid_o & m_ready_i)
            valid_n = 1'b0;

        if (in_xfer) begin
            if (cnt == LAST) begin
                data_n  = {s_data_i, acc};
                valid_n = 1'b1;
                cnt_n   = '0;
`ifdef AXIS_PACKER_FLUSH_EN
                count_n = MW'(RATIO);
`endif
            end else begin
                for (int i = 0; i < RATIO - 1; i++)
                    if (cnt == CW'(i))
                        acc_n[i*IN_WIDTH +: IN_WIDTH] = s_data_i;
                cnt_n = cnt + 1'b1;
            end
        end

`ifdef AXIS_PACKER_FLUSH_EN
        // in_xfer is blocked while pending, so emission never races a beat
        if (flush_pend & slot_free) begin
            data_n = '0;
            for (int i = 0; i < RATIO - 1; i++)
                if (i < int'(cnt))
                    data_n[i*IN_WIDTH +: IN_WIDTH] = acc[i*IN_WIDTH +: IN_WIDTH];
            count_n = MW'(cnt);
            valid_n = 1'b1;
            cnt_n   = '0;
            pend_n  = 1'b0;
        end else if (flush_i & !flush_pend & (cnt_n != '0)) begin
            pend_n = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt       <= '0;
            acc       <= '0;
            m_data_o  <= '0;
            m_valid_o <= 1'b0;
`ifdef AXIS_PACKER_FLUSH_EN
            m_count_o  <= '0;
            flush_pend <= 1'b0;
`endif
        end else begin
            cnt       <= cnt_n;
            acc       <= acc_n;
            m_data_o  <= data_n;
            m_valid_o <= valid_n;
`ifdef AXIS_PACKER_FLUSH_EN
            m_count_o  <= count_n;
            flush_pend <= pend_n;
`endif
        end
    end

endmodule
